// File: rtl/al_time_keeper_pkg.sv
// Shared time-keeper definitions: BCD limits, blank-digit code, default reset times.
// Also holds the BCD helper functions used by the counters and the top.
// Pure package; no state.
package al_time_keeper_pkg;

  localparam logic [7:0]  SEC_MAX         = 8'h59;
  localparam logic [7:0]  MIN_MAX         = 8'h59;
  localparam logic [7:0]  HOUR_MAX        = 8'h23;
  localparam logic [3:0]  BLANK_DIGIT     = 4'hF;
  localparam logic [15:0] DEF_RESET_TIME  = 16'h1200;
  localparam logic [15:0] DEF_RESET_ALARM = 16'h0000;

  // A digit the operator has not typed yet (BLANK_DIGIT) is never a legal value.
  function automatic logic digit_ok(input logic [3:0] d);
    return (d != BLANK_DIGIT) && (d <= 4'd9);
  endfunction

  // HHMM is loadable only if all four digits are decimal and the fields are in range.
  function automatic logic valid_hhmm(input logic [15:0] k);
    return digit_ok(k[15:12]) && digit_ok(k[11:8]) && digit_ok(k[7:4]) && digit_ok(k[3:0])
        && (k[15:8] <= HOUR_MAX) && (k[7:0] <= MIN_MAX);
  endfunction

  // Two-digit BCD increment without range wrap; callers handle their own max.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // HHMM + 9 minutes in BCD, wrapping 23:5x to 00:0x.
  function automatic logic [15:0] hhmm_plus9(input logic [15:0] t);
    logic [3:0] ht, ho, mt, mo;
    {ht, ho, mt, mo} = t;
    if (mo == 4'd0) begin
      mo = 4'd9;
    end else begin
      mo = mo - 4'd1;
      mt = mt + 4'd1;
    end
    if (mt == 4'd6) begin
      mt = 4'd0;
      if ({ht, ho} == HOUR_MAX) begin
        ht = 4'd0;
        ho = 4'd0;
      end else if (ho == 4'd9) begin
        ho = 4'd0;
        ht = ht + 4'd1;
      end else begin
        ho = ho + 4'd1;
      end
    end
    return {ht, ho, mt, mo};
  endfunction

endpackage

// File: rtl/al_time_keeper_if.sv
// Bundle between the alarm-clock controller/display side and the time keeper.
// master = controller side (drives strobes, reads time); slave = time keeper.
// All keeper outputs are registered.
interface al_time_keeper_if;
  logic        one_second;
  logic [15:0] key_buffer;
  logic        load_new_time;
  logic        load_alarm;
  logic        alarm_enable;
  logic        snooze;
  logic [15:0] current_time;
  logic [7:0]  current_seconds;
  logic [15:0] alarm_time;
  logic        alarm_sound;
  logic        load_error;

  modport master (
    output one_second, key_buffer, load_new_time, load_alarm, alarm_enable, snooze,
    input  current_time, current_seconds, alarm_time, alarm_sound, load_error
  );

  modport slave (
    input  one_second, key_buffer, load_new_time, load_alarm, alarm_enable, snooze,
    output current_time, current_seconds, alarm_time, alarm_sound, load_error
  );
endinterface

// File: rtl/al_bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with synchronous load, increment enable and carry-out.
// Latency: value updates one clock after load/inc; next_val and carry are combinational.
// No backpressure; load has priority over increment.
module al_bcd_mod_counter
  import al_time_keeper_pkg::*;
#(
  parameter logic [7:0] MAX       = 8'h59,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       inc,
  output logic [7:0] value,
  output logic [7:0] next_val,
  output logic       carry
);

  assign carry = inc && (value == MAX);

  // Next digit pair: load wins, otherwise BCD increment wrapping MAX to 00.
  always_comb begin
    next_val = value;
    if (load) begin
      next_val = load_val;
    end else if (inc) begin
      next_val = (value == MAX) ? 8'h00 : bcd_inc(value);
    end
  end

  // Register the digit pair.
  always_ff @(posedge clk) begin
    if (reset) value <= RESET_VAL;
    else       value <= next_val;
  end

endmodule

// File: rtl/al_time_keeper.sv
// Time-of-day HH:MM:SS keeper with alarm setpoint and timed alarm output; AL_SNOOZE_EN adds snooze.
// Latency: every output is registered, effects show one clock after the strobe or tick.
// No backpressure: strobes are single-cycle and always accepted or flagged via load_error.
module al_time_keeper
  import al_time_keeper_pkg::*;
#(
  parameter logic [15:0] RESET_TIME       = DEF_RESET_TIME,
  parameter logic [15:0] RESET_ALARM      = DEF_RESET_ALARM,
  parameter logic [7:0]  ALARM_DURATION_S = 8'd60
) (
  input  logic             clk,
  input  logic             reset,
  al_time_keeper_if.slave  tk
);

  logic        load_ok, time_load, alarm_load, tick_cnt;
  logic [7:0]  ss_q, mm_q, hh_q, mm_next, hh_next, ss_next_unused;
  logic        ss_carry, mm_carry, hh_wrap_unused;
  logic [15:0] alarm_q, next_hhmm;
  logic [7:0]  dur_cnt;
  logic        sound_q, load_err_q;
  logic        minute_edge, hit_alarm, hit_snooze, snooze_stop, fire;

  assign load_ok    = valid_hhmm(tk.key_buffer);
  assign time_load  = tk.load_new_time && load_ok;
  assign alarm_load = tk.load_alarm && load_ok;
  // A valid time load swallows a coincident tick.
  assign tick_cnt   = tk.one_second && !time_load;

  al_bcd_mod_counter #(.MAX(SEC_MAX), .RESET_VAL(8'h00)) u_ss (
    .clk(clk), .reset(reset), .load(time_load), .load_val(8'h00), .inc(tick_cnt),
    .value(ss_q), .next_val(ss_next_unused), .carry(ss_carry)
  );
  al_bcd_mod_counter #(.MAX(MIN_MAX), .RESET_VAL(RESET_TIME[7:0])) u_mm (
    .clk(clk), .reset(reset), .load(time_load), .load_val(tk.key_buffer[7:0]), .inc(ss_carry),
    .value(mm_q), .next_val(mm_next), .carry(mm_carry)
  );
  al_bcd_mod_counter #(.MAX(HOUR_MAX), .RESET_VAL(RESET_TIME[15:8])) u_hh (
    .clk(clk), .reset(reset), .load(time_load), .load_val(tk.key_buffer[15:8]), .inc(mm_carry),
    .value(hh_q), .next_val(hh_next), .carry(hh_wrap_unused)
  );

  // Triggers only fire when counting crosses into a new minute, never on a load.
  assign next_hhmm   = {hh_next, mm_next};
  assign minute_edge = tick_cnt && ss_carry;
  assign hit_alarm   = minute_edge && tk.alarm_enable && (next_hhmm == alarm_q);
  assign fire        = hit_alarm || hit_snooze;

`ifdef AL_SNOOZE_EN
  logic [15:0] snooze_target;
  logic        snooze_armed;

  assign hit_snooze  = snooze_armed && minute_edge && tk.alarm_enable && (next_hhmm == snooze_target);
  assign snooze_stop = tk.snooze && sound_q && tk.alarm_enable && !alarm_load && !fire;

  // Snooze target: latched on snooze while sounding, dropped when it fires or is cancelled.
  always_ff @(posedge clk) begin
    if (reset) begin
      snooze_armed  <= 1'b0;
      snooze_target <= 16'h0000;
    end else if (!tk.alarm_enable || alarm_load || hit_snooze) begin
      snooze_armed  <= 1'b0;
    end else if (snooze_stop) begin
      snooze_armed  <= 1'b1;
      snooze_target <= hhmm_plus9({hh_q, mm_q});
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = tk.snooze;
  assign hit_snooze    = 1'b0;
  assign snooze_stop   = 1'b0;
`endif

  // Alarm setpoint and one-cycle rejected-load flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_q    <= RESET_ALARM;
      load_err_q <= 1'b0;
    end else begin
      if (alarm_load) alarm_q <= tk.key_buffer;
      load_err_q <= (tk.load_new_time || tk.load_alarm) && !load_ok;
    end
  end

  // Alarm output and its duration countdown; counter saturates at zero.
  always_ff @(posedge clk) begin
    if (reset || !tk.alarm_enable || alarm_load) begin
      sound_q <= 1'b0;
      dur_cnt <= 8'd0;
    end else if (fire) begin
      sound_q <= 1'b1;
      dur_cnt <= ALARM_DURATION_S;
    end else if (snooze_stop) begin
      sound_q <= 1'b0;
      dur_cnt <= 8'd0;
    end else if (tk.one_second && (dur_cnt != 8'd0)) begin
      dur_cnt <= dur_cnt - 8'd1;
      if (dur_cnt == 8'd1) sound_q <= 1'b0;
    end
  end

  assign tk.current_time    = {hh_q, mm_q};
  assign tk.current_seconds = ss_q;
  assign tk.alarm_time      = alarm_q;
  assign tk.alarm_sound     = sound_q;
  assign tk.load_error      = load_err_q;

endmodule
